ram2_arbiter: RTL and testbench

Two-port round-robin arbiter that shares the single-port 32×32 `ram2` between requester A and requester B. It serializes their read/write transactions and drives `ram2`'s `ena`/`wena`/`addr` and bidirectional `data` bus. Each requester returns read data and a one-cycle `ack`. The arbiter sits directly in front of `ram2`, which stays unmodified: a write commits on `clk` rising edge when `ena & wena`, and a read is combinational when `ena & ~wena`, else the bus is `z`.

---
 rtl/ram_ctrl_pkg.sv | 9 +
 rtl/ram2_arbiter_rr_arb2.sv | 20 ++
 rtl/ram2_arbiter.sv | 83 ++++++++
 tb/tb_ram2_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared widths, FSM encoding and port ids for the ram2 arbiter.
package ram_ctrl_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic IDLE = 1'b0;
    localparam logic ACCESS = 1'b1;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/ram2_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; on a tie the port other than the last grantee wins.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);
    logic last_q, last_d;
    always_comb begin
        gnt = !grant_en ? 2'b00 : req == 2'b11 ? (last_q == PORT_B ? 2'b01 : 2'b10) : req;
        last_d = |gnt ? gnt[1] : last_q;
    end
    always_ff @(posedge clk) begin
        if (rst) last_q <= PORT_B;
        else     last_q <= last_d;
    end
endmodule

// File: rtl/ram2_arbiter.sv
// ram2_arbiter: serializes requesters A and B onto the single-port ram2 with a
// two-state FSM, one RAM cycle per grant and a one-cycle ack to the winner.
module ram2_arbiter #(
    parameter int ADDR_W = ram_ctrl_pkg::ADDR_W,
    parameter int DATA_W = ram_ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);
    import ram_ctrl_pkg::*;
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              id;
    } cmd_t;
    logic              state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [1:0]        gnt;
    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      ({b_req, a_req}),
        .grant_en (state_q == IDLE),
        .gnt      (gnt)
    );
    always_comb begin
        state_d   = (state_q == IDLE && |gnt) ? ACCESS : IDLE;
        cmd_d     = !(state_q == IDLE && |gnt) ? cmd_q :
                    gnt[1] ? cmd_t'{b_we, b_addr, b_wdata, PORT_B} :
                             cmd_t'{a_we, a_addr, a_wdata, PORT_A};
        a_ack_d   = state_q == ACCESS && cmd_q.id == PORT_A;
        b_ack_d   = state_q == ACCESS && cmd_q.id == PORT_B;
        a_rdata_d = (a_ack_d && !cmd_q.we) ? ram_data : a_rdata_q;
        b_rdata_d = (b_ack_d && !cmd_q.we) ? ram_data : b_rdata_q;
    end
    // Reset on the ACCESS exit edge drops the ack and read data; the RAM write still lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end
    assign busy     = state_q == ACCESS;
    assign ram_ena  = busy;
    assign ram_wena = busy && cmd_q.we;
    assign ram_addr = busy ? cmd_q.addr : '0;
    assign ram_data = (busy && cmd_q.we) ? cmd_q.wdata : 'z;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
endmodule

// File: tb/tb_ram2_arbiter.sv
// tb_ram2_arbiter: directed vectors against ram2_arbiter with a behavioral ram2 on the shared bus.
module tb_ram2_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [4:0]  a_addr = 0, b_addr = 0;
    logic [31:0] a_wdata = 0, b_wdata = 0;
    logic        a_ack, b_ack, busy, ram_ena, ram_wena;
    logic [31:0] a_rdata, b_rdata;
    logic [4:0]  ram_addr;
    wire  [31:0] ram_data;
    logic [31:0] mem [32];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    ram2_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .busy(busy), .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr), .ram_data(ram_data)
    );

    // ram2: combinational read onto the bus, write on the rising edge
    assign ram_data = (ram_ena && !ram_wena) ? mem[ram_addr] : 'z;
    always @(posedge clk) if (ram_ena && ram_wena) mem[ram_addr] <= ram_data;

    typedef struct {
        logic        port;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[8];
    logic [1:0] alt_pat[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic txn(input logic port, input logic we, input logic [4:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
        int lat = 0;
        logic ack = 0;
        if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
        while (!ack && lat < 6) begin
            tick();
            lat++;
            if (lat == 1) begin
                chk("access_busy", busy, 1);
                chk("access_addr", ram_addr, addr);
                chk("access_wena", ram_wena, we);
            end
            ack = port ? b_ack : a_ack;
            chk("other_ack", port ? a_ack : b_ack, 0);
        end
        a_req = 0;
        b_req = 0;
        chk("ack_latency", lat, 2);
        if (!we) chk("rdata", port ? b_rdata : a_rdata, exp);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        vt[0] = '{0, 1, 0,  32'hffffffff, 0};
        vt[1] = '{0, 0, 31, 0, 32'h00000000};
        vt[2] = '{0, 0, 0,  0, 32'hffffffff};
        vt[3] = '{1, 0, 5,  0, 32'h00000000};
        vt[4] = '{1, 1, 5,  32'h12345678, 0};
        vt[5] = '{1, 0, 5,  0, 32'h12345678};
        vt[6] = '{0, 1, 31, 32'ha5a5a5a5, 0};
        vt[7] = '{1, 0, 31, 0, 32'ha5a5a5a5};
        alt_pat = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

        tick();
        tick();
        rst = 0;
        repeat (5) tick();
        chk("rst_ram_ena", ram_ena, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_acks", {a_ack, b_ack}, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);

        for (int i = 0; i < 8; i++) txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp);

        // tie after B was last granted: A write goes first, B reads it back
        a_req = 1; a_we = 1; a_addr = 4; a_wdata = 32'h80008000;
        b_req = 1; b_we = 0; b_addr = 4;
        tick();
        chk("tie_first_wena", ram_wena, 1);
        chk("tie_first_addr", ram_addr, 4);
        tick();
        chk("tie_acks_1", {a_ack, b_ack}, 2'b10);
        a_req = 0;
        tick();
        chk("tie_second_busy", busy, 1);
        chk("tie_second_wena", ram_wena, 0);
        chk("tie_acks_3", {a_ack, b_ack}, 2'b00);
        tick();
        chk("tie_acks_2", {a_ack, b_ack}, 2'b01);
        chk("tie_b_rdata", b_rdata, 32'h80008000);
        b_req = 0;
        tick();

        // both requesting continuously: acks alternate A,B,A,B
        a_req = 1; a_we = 0; a_addr = 0;
        b_req = 1; b_we = 0; b_addr = 2;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("alt_acks", {a_ack, b_ack}, alt_pat[i]);
        end
        a_req = 0;
        b_req = 0;
        tick();
        chk("alt_a_rdata", a_rdata, 32'hffffffff);
        tick();

        // reset on the edge that ends a write ACCESS
        a_req = 1; a_we = 1; a_addr = 6; a_wdata = 32'hdeadbeef;
        tick();
        chk("rstw_busy", busy, 1);
        rst = 1;
        a_req = 0;
        tick();
        chk("rstw_a_ack", a_ack, 0);
        chk("rstw_busy_after", busy, 0);
        chk("rstw_a_rdata", a_rdata, 0);
        rst = 0;
        tick();
        txn(0, 0, 6, 0, 32'hdeadbeef);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
